// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder_pkg
// Purpose : Shared definitions for the CPU-to-SRAM memory responder:
//           funct3 access encodings, FSM state enum, and helpers that
//           classify an access (fault detection, write byte lanes).
// Rev     : 1.0  initial release
// ============================================================================
package mem_responder_pkg;

    // funct3 access size / sign encodings
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    // Stores reuse the signed load encodings
    localparam logic [2:0] c_F3_SB  = c_F3_LB;
    localparam logic [2:0] c_F3_SH  = c_F3_LH;
    localparam logic [2:0] c_F3_SW  = c_F3_LW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // An access faults if its funct3 is illegal for its direction or if the
    // address is not naturally aligned to the access size. Illegal funct3
    // values are handled exactly like misaligned accesses.
    function automatic logic access_fault(input logic       i_is_write,
                                          input logic [2:0] i_f3,
                                          input logic [1:0] i_ofs);
        logic w_legal;
        logic w_misal;
        if (i_is_write)
            w_legal = (i_f3 == c_F3_SB) || (i_f3 == c_F3_SH) || (i_f3 == c_F3_SW);
        else
            w_legal = (i_f3 == c_F3_LB)  || (i_f3 == c_F3_LH) || (i_f3 == c_F3_LW) ||
                      (i_f3 == c_F3_LBU) || (i_f3 == c_F3_LHU);
        w_misal = ((i_f3[1:0] == 2'b01) && i_ofs[0]) ||
                  ((i_f3[1:0] == 2'b10) && (i_ofs != 2'b00));
        return !w_legal || w_misal;
    endfunction

    // Byte lanes (bit n = byte n of the 32-bit word) touched by a store.
    function automatic logic [3:0] write_lanes(input logic [2:0] i_f3,
                                               input logic [1:0] i_ofs);
        logic [3:0] w_lanes;
        case (i_f3)
            c_F3_SB: w_lanes = 4'b0001 << i_ofs;
            c_F3_SH: w_lanes = i_ofs[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
        return w_lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_load_extract.sv
`default_nettype none
// ============================================================================
// Module  : load_extract
// Purpose : Combinational load data extraction. Selects the byte/halfword
//           addressed by the low address bits and sign- or zero-extends it.
// Ports   : i_word   - assembled 32-bit SRAM word
//           i_funct3 - load size/sign encoding
//           i_ofs    - byte offset within the word (mem_addr[1:0])
//           o_data   - extracted, extended load value
// Rev     : 1.0  initial release
// ============================================================================
module load_extract
    import mem_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_ofs,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_ofs)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_ofs[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            c_F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LH:  o_data = {{16{w_half[15]}}, w_half};
            c_F3_LW:  o_data = i_word;
            c_F3_LBU: o_data = {24'd0, w_byte};
            c_F3_LHU: o_data = {16'd0, w_half};
            default:  o_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder
// Purpose : Bridges CPU 32-bit load/store requests onto a 16-bit
//           asynchronous SRAM as two halfword cycles (LO then HI).
// Ports   : Clk, Reset          - clock, synchronous active-high reset
//           mem_addr/wdata/funct3 - CPU request (address, store data, size)
//           memR_En/memW_En     - read / write request levels
//           mem_rdata/ready/err - registered load data, completion, error
//           sram_*              - SRAM address, data and active-low strobes
// Rev     : 1.0  initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [2:0]        mem_funct3,
    input  logic              memR_En,
    input  logic              memW_En,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              mem_err,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [15:0]       sram_dq_i,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_r_prev;
    logic        r_w_prev;
    logic        r_is_write;
    logic        r_fault;       // misaligned / illegal: suppress write, zero read
    logic        r_err;         // fault or R/W conflict, reported to the CPU
    logic        r_used_r;      // enables that must stay high for this access
    logic        r_used_w;
    logic [2:0]  r_f3;
    logic [1:0]  r_ofs;
    logic [3:0]  r_lanes;
    logic [15:0] r_lo;
    logic [31:0] r_rdata;

    logic        w_r_rise;
    logic        w_w_rise;
    logic        w_start;
    logic        w_start_write;
    logic        w_conflict;
    logic        w_fault_nxt;
    logic        w_hold;
    logic        w_access;
    logic        w_half;
    logic [1:0]  w_lane_pair;
    logic [31:0] w_wword;
    logic [31:0] w_ext;
    logic        w_unused_addr;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_r_rise      = memR_En & ~r_r_prev;
    assign w_w_rise      = memW_En & ~r_w_prev;
    assign w_conflict    = w_r_rise & w_w_rise;
    assign w_start_write = w_w_rise & ~memR_En;
    // A rising enable starts an access only if the other enable is low,
    // except when both rise together (handled as an erroneous read).
    assign w_start       = (w_r_rise & ~memW_En) | w_start_write | w_conflict;
    assign w_fault_nxt   = access_fault(w_start_write, mem_funct3, mem_addr[1:0]);

    // Every enable that launched the access must still be high to continue.
    assign w_hold = (~r_used_r | memR_En) & (~r_used_w | memW_En);

    // ------------------------------------------------------------------
    // Next state and strobe decode (from registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        w_half      = 1'b0;
        w_lane_pair = 2'b00;
        sram_ce_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_ub_n   = 1'b1;
        sram_lb_n   = 1'b1;

        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_LO;
            ST_LO:   w_state_nxt = w_hold ? ST_HI : ST_IDLE;
            ST_HI:   w_state_nxt = w_hold ? ST_DONE : ST_IDLE;
            ST_DONE: if (!memR_En && !memW_En) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        w_access    = (r_state == ST_LO) || (r_state == ST_HI);
        w_half      = (r_state == ST_HI);
        w_lane_pair = w_half ? r_lanes[3:2] : r_lanes[1:0];

        if (w_access) begin
            sram_ce_n = 1'b0;
            sram_oe_n = r_is_write;
            sram_ub_n = ~w_lane_pair[1];
            sram_lb_n = ~w_lane_pair[0];
            if (r_is_write && (w_lane_pair != 2'b00)) begin
                sram_we_n  = 1'b0;
                sram_dq_oe = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Store data lane replication
    // ------------------------------------------------------------------
    always_comb begin
        case (r_f3)
            c_F3_SB: w_wword = {4{mem_wdata[7:0]}};
            c_F3_SH: w_wword = {2{mem_wdata[15:0]}};
            default: w_wword = mem_wdata;
        endcase
    end

    assign sram_dq_o     = w_half ? w_wword[31:16] : w_wword[15:0];
    assign sram_addr     = {mem_addr[ADDR_W:2], w_half};
    assign w_unused_addr = ^mem_addr[31:ADDR_W+1];

    // ------------------------------------------------------------------
    // Load extraction on the assembled word {HI halfword, latched LO}
    // ------------------------------------------------------------------
    load_extract u_load_extract (
        .i_word   ({sram_dq_i, r_lo}),
        .i_funct3 (r_f3),
        .i_ofs    (r_ofs),
        .o_data   (w_ext)
    );

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            // Treat enables as already high so a level held across reset
            // release is not mistaken for a new request.
            r_r_prev   <= 1'b1;
            r_w_prev   <= 1'b1;
            r_is_write <= 1'b0;
            r_fault    <= 1'b0;
            r_err      <= 1'b0;
            r_used_r   <= 1'b0;
            r_used_w   <= 1'b0;
            r_f3       <= 3'd0;
            r_ofs      <= 2'd0;
            r_lanes    <= 4'd0;
            r_lo       <= 16'd0;
            r_rdata    <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_r_prev <= memR_En;
            r_w_prev <= memW_En;

            if ((r_state == ST_IDLE) && w_start) begin
                r_is_write <= w_start_write;
                r_f3       <= mem_funct3;
                r_ofs      <= mem_addr[1:0];
                r_fault    <= w_fault_nxt;
                r_err      <= w_fault_nxt | w_conflict;
                r_used_r   <= ~w_start_write;
                r_used_w   <= w_start_write | w_conflict;
                // Reads always fetch both bytes; faulting stores touch nothing.
                if (w_start_write)
                    r_lanes <= w_fault_nxt ? 4'b0000 : write_lanes(mem_funct3, mem_addr[1:0]);
                else
                    r_lanes <= 4'b1111;
            end

            if ((r_state == ST_LO) && (w_state_nxt == ST_HI))
                r_lo <= sram_dq_i;

            if ((r_state == ST_HI) && (w_state_nxt == ST_DONE) && !r_is_write)
                r_rdata <= r_fault ? 32'd0 : w_ext;
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_ready = (r_state == ST_DONE);
    assign mem_err   = r_err;

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM halfword-address width.
REQ-002 Clk  input  1  system clock; all state changes on posedge Clk.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 mem_addr  input  32  byte address from the CPU MAR.
REQ-005 mem_wdata  input  32  store data from the CPU (rs2 value).
REQ-006 mem_funct3  input  3  access size/sign; the datapath drives 3'b010 during instruction fetch.
REQ-007 memR_En  input  1  CPU read request, held high for 3 consecutive cycles.
REQ-008 memW_En  input  1  CPU write request, held high for 3 consecutive cycles.
REQ-009 mem_rdata  output  32  registered, size-extracted read data for the CPU MDR.
REQ-010 mem_ready  output  1  high while the current access has completed.
REQ-011 mem_err  output  1  sticky per-access error: misaligned, illegal funct3, or R/W conflict.
REQ-012 sram_addr  output  ADDR_W  halfword address {mem_addr[ADDR_W:2], half}.
REQ-013 sram_dq_i  input  16  SRAM read data (asynchronous SRAM).
REQ-014 sram_dq_o  output  16  SRAM write data.
REQ-015 sram_dq_oe  output  1  drive enable for the top-level tristate.
REQ-016 sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes.

Function
REQ-017 FSM states SHALL be IDLE, LO, HI, DONE.
REQ-018 IDLE->LO SHALL occur when exactly one enable is high and was low in the previous cycle (rising edge); the access type is latched then.
REQ-019 LO->HI->DONE SHALL each take 1 cycle; DONE SHALL persist until both enables are low, then go to IDLE.
REQ-020 Any enable falling low in LO or HI SHALL abort to IDLE without further SRAM strobes; mem_rdata retains its old value.
REQ-021 LO SHALL access halfword 0 (sram_addr LSB=0) and HI halfword 1; sram_ce_n SHALL be low only in LO/HI.
REQ-022 Read: sram_oe_n low in LO/HI; sram_dq_i registered at the end of LO (low half) and HI (high half); mem_rdata SHALL be valid from the first DONE cycle, i.e. the 3rd enable cycle.
REQ-023 Read extraction: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; byte/half selected by mem_addr[1:0].
REQ-024 Write: sram_we_n low and sram_dq_oe high only in LO/HI cycles whose byte lanes are enabled; sram_ub_n/sram_lb_n select lanes.
REQ-025 Write lanes: SB sets the lane at mem_addr[1:0] and replicates wdata[7:0]; SH sets lanes per mem_addr[1]; SW sets all four lanes.
REQ-026 Misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL set mem_err; a faulting write issues no SRAM write, and a faulting read returns 0.
REQ-027 funct3 011/110/111 on a read, or anything other than 000/001/010 on a write, SHALL set mem_err and behave as a misaligned access.
REQ-028 Both enables rising together SHALL be treated as a read with mem_err=1.
REQ-029 mem_ready SHALL be high exactly in DONE; mem_err SHALL be cleared on each new IDLE->LO transition.
REQ-030 SRAM strobes SHALL be glitch-free registered outputs or decoded from registered state only.

Reset
REQ-031 Reset SHALL force IDLE, mem_rdata=0, mem_ready=0, mem_err=0, sram_dq_oe=0, and all SRAM strobes high (inactive), overriding any in-flight access.
REQ-032 The first request after Reset deasserts SHALL require an enable rising edge; an enable already high when Reset deasserts SHALL be ignored.

Structure
REQ-033 The funct3 size encodings and the state enum SHALL be placed in the shared definitions package.
REQ-034 Read extraction (REQ-023) SHALL be a combinational sub-module load_extract; all other logic lives in mem_responder.

Verification
REQ-035 Run LW at 0x00000010 with SRAM[8]=0x5678, SRAM[9]=0x1234 -> mem_rdata=0x12345678 in cycle 3, mem_ready=1, mem_err=0.
REQ-036 Run LB at 0x00000013 on the same word, then LBU -> 0x00000012, then 0x00000012; a subsequent LH at 0x12 with upper halfword 0x8001 -> 0xFFFF8001.
REQ-037 Run SB 0x000000AB at 0x00000021 -> one SRAM write in LO with sram_ub_n=0, sram_lb_n=1, sram_dq_o=0xABAB; no write in HI.
REQ-038 Run SW at 0x00000002 -> mem_err=1, no sram_we_n pulse, and DONE is reached on cycle 3.
REQ-039 Assert Reset during HI of a read, and separately drop memR_En during LO -> IDLE next cycle, strobes inactive, mem_rdata unchanged (0 after Reset).
REQ-040 Raise memR_En and memW_En together -> read performed, mem_err=1, no SRAM write.
